// File: rtl/flag_pkg.sv
// Shared types and helpers for the three-way flag arbiter: FSM states, requester
// indices, index arithmetic modulo 3 and the contention-flag definition.
package flag_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [1:0] REQ_X = 2'd0;
    localparam logic [1:0] REQ_Y = 2'd1;
    localparam logic [1:0] REQ_Z = 2'd2;

    // One-hot decode of a requester index; the unused code 3 maps to no requester.
    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        logic [2:0] oh;
        oh = 3'b000;
        case (idx)
            REQ_X:   oh = 3'b001;
            REQ_Y:   oh = 3'b010;
            REQ_Z:   oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // (a + b) mod 3 for a in 0..2 and b in 0..3.
    function automatic logic [1:0] idx_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    // Contention: x with y, or y with z, requesting together.
    function automatic logic contention(input logic [2:0] req);
        return (req[REQ_X] & req[REQ_Y]) | (req[REQ_Y] & req[REQ_Z]);
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin selector: searches ptr+1, ptr+2, ptr (mod 3) and
// returns the first requester found.
module rr_pick3
    import flag_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] winner,
    output logic       any
);

    logic [1:0] cand [3];
    logic [2:0] hit;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_order
            assign cand[gi] = idx_add(ptr, 2'(gi + 1));
            assign hit[gi]  = |(req & onehot3(cand[gi]));
        end
    endgenerate

    assign any = |hit;

    always_comb begin
        winner = cand[0];
        if (hit[0]) begin
            winner = cand[0];
        end else if (hit[1]) begin
            winner = cand[1];
        end else if (hit[2]) begin
            winner = cand[2];
        end
    end

endmodule

// File: rtl/flag_rr_arbiter.sv
// Round-robin arbiter for the x/y/z flag sources with a bounded hold time,
// a one-cycle release gap and a registered contention flag.
module flag_rr_arbiter
    import flag_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       done,
    output logic [2:0] gnt,
    output logic       busy,
    output logic       flag,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       idx_reg;
    logic [1:0]       ptr_reg;
    logic [2:0]       gnt_reg;
    logic             busy_reg;
    logic             flag_reg;
    logic             timeout_reg;

    logic [1:0] winner;
    logic       any;
    logic       owner_req;
    logic       hit_limit;
    logic       early_release;

    rr_pick3 u_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .winner (winner),
        .any    (any)
    );

    assign owner_req     = |(req & onehot3(idx_reg));
    assign hit_limit     = (cnt_reg == CNT_LAST);
    // A grantee finishing or dropping its request outranks the hold limit.
    assign early_release = done || !owner_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            idx_reg     <= REQ_X;
            ptr_reg     <= REQ_Z;
            gnt_reg     <= 3'b000;
            busy_reg    <= 1'b0;
            flag_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            flag_reg    <= contention(req);
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any) begin
                        state_reg <= GRANT;
                        idx_reg   <= winner;
                        ptr_reg   <= winner;
                        cnt_reg   <= '0;
                        gnt_reg   <= onehot3(winner);
                        busy_reg  <= 1'b1;
                    end
                end
                GRANT: begin
                    if (early_release || hit_limit) begin
                        state_reg   <= RELEASE;
                        gnt_reg     <= 3'b000;
                        timeout_reg <= !early_release;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= 3'b000;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_reg;
    assign busy    = busy_reg;
    assign flag    = flag_reg;
    assign timeout = timeout_reg;

endmodule

// File: doc/flag_rr_arbiter.md
# flag_rr_arbiter

Round-robin arbiter that shares one downstream resource among three flag requesters (x, y, z → req[0], req[1], req[2]). It grants one requester at a time and bounds each grant with a hold counter. A one-cycle dead cycle separates consecutive grants. It also publishes a registered contention flag: set when requester pairs (x,y) or (y,z) are active together. The block sits in front of the flag-evaluation datapath and sequences which source drives it.

## Interface
- HOLD_MAX, 8: maximum cycles a grant may be held before forced release; legal range 2..255.
- CNT_W, 8: width of hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  rising-edge clock; the only clock in the block.
- rst  input  1  synchronous, active-high reset.
- req  input  3  request vector; bit 0 = x, bit 1 = y, bit 2 = z; level-sensitive.
- done  input  1  current grantee finished; sampled only in GRANT.
- gnt  output  3  registered one-hot grant; all-zero when no grant is active.
- busy  output  1  registered; high in GRANT and RELEASE.
- flag  output  1  registered contention flag: (req[0]&req[1]) | (req[1]&req[2]), sampled every cycle.
- timeout  output  1  registered one-cycle pulse when a grant is force-released at HOLD_MAX.

## Operation
- State machine has three states.
  - IDLE: gnt = 0, busy = 0.
  - GRANT: gnt = one-hot of idx, busy = 1.
  - RELEASE: gnt = 0, busy = 1; lasts exactly one cycle, then returns to IDLE.
- Round-robin pointer ptr (2 bits, values 0..2) holds the last granted index.
  - Search order is ptr+1, ptr+2, ptr (mod 3).
  - The first set req bit in that order wins.
- IDLE → GRANT when req != 0.
  - On that edge: idx ← winner, cnt ← 0, ptr ← winner.
- GRANT → RELEASE on the first edge where any of these holds:
  - done = 1;
  - req[idx] = 0;
  - cnt = HOLD_MAX-1.
  - Otherwise cnt increments by 1 (no wrap is possible within the legal range).
- Release priority: done or request drop wins over the counter.
  - If done = 1 or req[idx] = 0 on the same edge that cnt = HOLD_MAX-1, timeout stays 0.
  - timeout = 1 for one cycle only when the release is caused solely by the counter.
- Requests arriving or changing while in GRANT or RELEASE are not latched. Arbitration in IDLE uses the req value at that edge.
- The flag output is independent of the FSM: flag ← (req[0]&req[1]) | (req[1]&req[2]) on every edge, including during GRANT and RELEASE.
- Reset, including mid-grant, sets:
  - state = IDLE, gnt = 0, busy = 0, flag = 0, timeout = 0;
  - cnt = 0, idx = 0;
  - ptr = 2, so the first search order is 0, 1, 2.

## Timing
- Grant latency: req sampled high in IDLE at edge k → gnt valid in the cycle after edge k.
  - Minimum is 1 cycle from the first edge where req is visible.
- Maximum grant length is HOLD_MAX cycles of gnt high.
- Every grant is followed by exactly 1 cycle of gnt = 0 (RELEASE), plus at least 1 IDLE cycle.
  - Back-to-back grants are therefore spaced by 2 cycles of gnt = 0.
- done is a single-cycle or level input; only its value at edges while in GRANT matters.
- flag latency: 1 cycle after req.
- timeout is asserted during the RELEASE cycle that follows the forced release.
- No combinational path from any input to any output.

## Structure
- Shared package flag_pkg holds:
  - the state enum (IDLE, GRANT, RELEASE);
  - the request-index constants REQ_X = 0, REQ_Y = 1, REQ_Z = 2;
  - the contention-flag function (req[0]&req[1]) | (req[1]&req[2]), so the flag datapath and the arbiter share one definition.
- One natural sub-module is rr_pick3: a combinational round-robin selector.
  - Inputs: req[2:0], ptr.
  - Outputs: winner[1:0], any.
  - The top level holds the FSM, counter, pointer and output registers.

## Test plan
- Reset then single request:
  - Stimulus: rst 2 cycles; req = 3'b010 held; done pulsed at the 3rd GRANT cycle.
  - Required: gnt = 3'b010 from the cycle after the first sample, for 3 cycles; then 1 RELEASE cycle with busy = 1; then IDLE; then re-grant to y.
- Round-robin fairness:
  - Stimulus: req = 3'b111 held; done pulsed each grant after 1 cycle.
  - Required: grant order x, y, z, x, y; exactly 2 zero-gnt cycles between consecutive grants.
- Timeout, HOLD_MAX = 4:
  - Stimulus: req = 3'b100 held; done = 0.
  - Required: gnt = 3'b100 for exactly 4 cycles; timeout = 1 in the following cycle only; then z is re-granted after IDLE.
- done coincident with limit:
  - Stimulus: done = 1 on the edge where cnt = HOLD_MAX-1.
  - Required: release occurs and timeout stays 0.
- Contention flag:
  - Stimulus: sweep req through 000, 001, 011, 101, 110, 111.
  - Required: flag one cycle later is 0, 0, 1, 0, 1, 1.
- Reset mid-grant:
  - Stimulus: assert rst during GRANT of y.
  - Required: on the next cycle gnt = 0, busy = 0, timeout = 0, flag = 0; after release of rst with req = 3'b111, x is granted first.
